// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundle between the five-stage MIPS datapath and its sequencing controller.
//
// Signals:
//   Datapath -> controller (hazard sources)
//     id_rs, id_rt       register fields of the instruction in ID
//     id_uses_rt         ID instruction actually reads rt
//     ex_mem_read        instruction in EX is a load
//     ex_write_address   destination register of the instruction in EX
//     mem_branch         instruction in MEM is a branch
//     mem_zflag          zero flag out of the EX/MEM buffer
//   Controller -> datapath (sequencing controls)
//     pc_en, pc_src      PC load enable / branch-target select
//     if_id_en           IF/ID load enable
//     *_flush            load a bubble into the named pipeline buffer
//     init_done          startup flush finished
//     stall_count        load-use stalls seen (zero unless statistics built)
//     flush_count        taken-branch flushes seen (zero unless statistics built)
//
// Modports:
//   master  datapath side
//   slave   controller side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_write_address;
   logic        mem_branch;
   logic        mem_zflag;

   logic        pc_en;
   logic        pc_src;
   logic        if_id_en;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        ex_mem_flush;
   logic        mem_wb_flush;
   logic        init_done;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_address, mem_branch, mem_zflag,
      input  pc_en, pc_src, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
      input  init_done, stall_count, flush_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_address, mem_branch, mem_zflag,
      output pc_en, pc_src, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
      output init_done, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the five-stage MIPS datapath. After reset
// it holds all four (unreset) pipeline buffers in bubble state for INIT_CYCLES
// cycles, then runs the pipeline, inserting a one-cycle stall on a load-use
// dependency and squashing the three wrong-path instructions when a branch
// resolves taken in MEM.
//
// Parameters:
//   INIT_CYCLES  cycles spent flushing after reset, 1..15
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   hazard_ctrl_if.slave: hazard inputs in, PC/buffer controls out
//
// Build option:
//   HAZARD_STATS_EN  when defined, builds saturating 16-bit stall and flush
//                    counters; otherwise stall_count/flush_count tie to zero.
//
// Control outputs are combinational from state and inputs so the PC and the
// buffers act on them at the very next edge. Because the state register resets
// asynchronously, the bubble controls assert as soon as rst rises.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned INIT_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      StInit  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2
   } state_e;

   localparam logic [3:0] InitLast = 4'(INIT_CYCLES - 1);

   state_e     state_q;
   logic [3:0] init_cnt_q;

   logic taken;
   logic load_use;
   logic rs_match;
   logic rt_match;

   // Hazard terms. Register 0 is hardwired, so a load targeting it is harmless.
   assign taken    = bus.mem_branch & bus.mem_zflag;
   assign rs_match = (bus.ex_write_address == bus.id_rs);
   assign rt_match = bus.id_uses_rt & (bus.ex_write_address == bus.id_rt);
   assign load_use = bus.ex_mem_read & (bus.ex_write_address != 5'd0) & (rs_match | rt_match);

   // ---------------------------------------------------------------------------
   // Sequencing state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StInit;
         init_cnt_q <= 4'd0;
      end else begin
         unique case (state_q)
            StInit: begin
               if (init_cnt_q == InitLast) begin
                  state_q    <= StRun;
                  init_cnt_q <= 4'd0;
               end else begin
                  init_cnt_q <= init_cnt_q + 4'd1;
               end
            end
            StRun: begin
               if (taken) begin
                  state_q <= StFlush;
               end
            end
            StFlush: begin
               // The squashed ID slot cannot hold a dependent instruction and
               // MEM cannot hold a branch yet, so one plain cycle is enough.
               state_q <= StRun;
            end
            default: begin
               state_q    <= StInit;
               init_cnt_q <= 4'd0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Control outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      // Bubble everything by default; this is also the INIT behaviour.
      bus.pc_en        = 1'b0;
      bus.pc_src       = 1'b0;
      bus.if_id_en     = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
      bus.mem_wb_flush = 1'b1;
      bus.init_done    = 1'b0;

      unique case (state_q)
         StRun: begin
            bus.init_done    = 1'b1;
            bus.pc_en        = 1'b1;
            bus.if_id_flush  = 1'b0;
            bus.id_ex_flush  = 1'b0;
            bus.ex_mem_flush = 1'b0;
            bus.mem_wb_flush = 1'b0;
            if (taken) begin
               // Squash IF, ID and EX; the branch itself retires through MEM/WB.
               bus.pc_src       = 1'b1;
               bus.if_id_flush  = 1'b1;
               bus.id_ex_flush  = 1'b1;
               bus.ex_mem_flush = 1'b1;
            end else if (load_use) begin
               // Freeze PC and IF/ID, send a bubble down ID/EX for one cycle.
               bus.pc_en       = 1'b0;
               bus.if_id_en    = 1'b0;
               bus.id_ex_flush = 1'b1;
            end
         end
         StFlush: begin
            bus.init_done    = 1'b1;
            bus.pc_en        = 1'b1;
            bus.if_id_flush  = 1'b0;
            bus.id_ex_flush  = 1'b0;
            bus.ex_mem_flush = 1'b0;
            bus.mem_wb_flush = 1'b0;
         end
         default: begin
            // StInit and any unused encoding keep the bubble defaults.
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Optional hazard statistics
   // ---------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;
   logic        run_cycle;

   assign run_cycle = (state_q == StRun);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         if (run_cycle && load_use && !taken && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (run_cycle && taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
`else
   assign bus.stall_count = 16'd0;
   assign bus.flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Scoreboarded bench for hazard_ctrl. A driver applies one stimulus vector per
// cycle shortly after the rising edge and pushes the reference model's expected
// outputs; a monitor pops and compares on the falling edge. The model tracks
// the pipeline at the level of "edges since reset" and "last cycle was a taken
// branch", not the controller's state encoding.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int unsigned INIT = 4;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       mem_read;
      logic [4:0] wa;
      logic       br;
      logic       z;
   } stim_t;

   typedef struct packed {
      logic        pc_en;
      logic        pc_src;
      logic        if_id_en;
      logic        if_id_flush;
      logic        id_ex_flush;
      logic        ex_mem_flush;
      logic        mem_wb_flush;
      logic        init_done;
      logic [15:0] stall_count;
      logic [15:0] flush_count;
   } out_t;

   logic clk;
   logic rst;

   hazard_ctrl_if bus ();

   hazard_ctrl #(
      .INIT_CYCLES (INIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_cycle  = 0;
   out_t exp_q[$];

   // Reference model state
   int m_edges    = 0;   // rising edges seen since reset released
   bit m_after_br = 0;   // previous cycle squashed a taken branch
   int m_stalls   = 0;
   int m_flushes  = 0;

   function automatic out_t actual_out();
      out_t a;
      a.pc_en        = bus.pc_en;
      a.pc_src       = bus.pc_src;
      a.if_id_en     = bus.if_id_en;
      a.if_id_flush  = bus.if_id_flush;
      a.id_ex_flush  = bus.id_ex_flush;
      a.ex_mem_flush = bus.ex_mem_flush;
      a.mem_wb_flush = bus.mem_wb_flush;
      a.init_done    = bus.init_done;
      a.stall_count  = bus.stall_count;
      a.flush_count  = bus.flush_count;
      return a;
   endfunction

   task automatic compare(input string name, input out_t got, input out_t want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s @cycle %0d: got ctl=%b stalls=%0d flushes=%0d, expected ctl=%b stalls=%0d flushes=%0d",
                  name, n_cycle, got[39:32], got.stall_count, got.flush_count,
                  want[39:32], want.stall_count, want.flush_count);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         compare("cycle", actual_out(), exp_q.pop_front());
      end
   end

   function automatic stim_t rand_stim();
      stim_t s;
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.uses_rt  = 1'($urandom_range(0, 1));
      s.mem_read = 1'($urandom_range(0, 1));
      s.wa       = 5'($urandom_range(0, 3));
      s.br       = ($urandom_range(0, 3) == 0);
      s.z        = 1'($urandom_range(0, 1));
      return s;
   endfunction

   function automatic stim_t mk(input int rs, input int rt, input bit uses_rt, input bit rd,
                                input int wa, input bit br, input bit z);
      stim_t s;
      s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rt = uses_rt; s.mem_read = rd;
      s.wa = 5'(wa); s.br = br; s.z = z;
      return s;
   endfunction

   // One cycle: drive, predict, push, advance model.
   task automatic step(input bit r, input stim_t s);
      out_t e;
      bit   lu;
      bit   tk;
      @(posedge clk);
      #1;
      n_cycle++;
      rst                  = r;
      bus.id_rs            = s.rs;
      bus.id_rt            = s.rt;
      bus.id_uses_rt       = s.uses_rt;
      bus.ex_mem_read      = s.mem_read;
      bus.ex_write_address = s.wa;
      bus.mem_branch       = s.br;
      bus.mem_zflag        = s.z;

      lu = s.mem_read && (s.wa != 0) && ((s.wa == s.rs) || (s.uses_rt && (s.wa == s.rt)));
      tk = s.br && s.z;

      if (r) begin
         m_edges = 0; m_after_br = 0; m_stalls = 0; m_flushes = 0;
      end

      e = '0;
      if (r || (m_edges < INIT)) begin
         e.if_id_en = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
         e.ex_mem_flush = 1; e.mem_wb_flush = 1;
      end else begin
         e.init_done = 1;
         e.pc_en     = 1;
         e.if_id_en  = 1;
         if (!m_after_br && tk) begin
            e.pc_src = 1; e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1;
         end else if (!m_after_br && lu) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
         end
      end
`ifdef HAZARD_STATS_EN
      e.stall_count = 16'(m_stalls);
      e.flush_count = 16'(m_flushes);
`endif
      exp_q.push_back(e);

      if (!r) begin
         if (m_edges < INIT) begin
            m_edges++;
         end else if (m_after_br) begin
            m_after_br = 0;
         end else if (tk) begin
            m_after_br = 1;
            if (m_flushes < 65535) m_flushes++;
         end else if (lu) begin
            if (m_stalls < 65535) m_stalls++;
         end
      end
   endtask

   stim_t quiet;

   initial begin
      rst                  = 1'b1;
      bus.id_rs            = '0;
      bus.id_rt            = '0;
      bus.id_uses_rt       = 1'b0;
      bus.ex_mem_read      = 1'b0;
      bus.ex_write_address = '0;
      bus.mem_branch       = 1'b0;
      bus.mem_zflag        = 1'b0;
      quiet                = mk(1, 2, 1, 0, 0, 0, 0);

      // Reset held, then the INIT sequence and first RUN cycles.
      repeat (3) step(1, quiet);
      repeat (7) step(0, quiet);

      // Load-use on rs, then the load has moved on.
      step(0, mk(8, 3, 0, 1, 8, 0, 0));
      step(0, quiet);
      // Register 0 never hazards; rt only when it is read.
      step(0, mk(0, 0, 1, 1, 0, 0, 0));
      step(0, mk(4, 9, 0, 1, 9, 0, 0));
      step(0, mk(4, 9, 1, 1, 9, 0, 0));
      // Back-to-back dependent loads: one stall per load.
      step(0, mk(5, 0, 0, 1, 5, 0, 0));
      step(0, mk(6, 0, 0, 1, 6, 0, 0));
      // Taken branch with a load-use present, then FLUSH with both ignored.
      step(0, mk(7, 7, 1, 1, 7, 1, 1));
      step(0, mk(7, 7, 1, 1, 7, 1, 1));
      step(0, mk(7, 7, 1, 1, 7, 0, 0));
      // Not-taken branch behaves as plain RUN.
      step(0, mk(1, 1, 1, 0, 2, 1, 0));

      repeat (300) step(0, rand_stim());

      // Asynchronous reset in the middle of a stall cycle.
      step(0, quiet);
      step(0, mk(8, 3, 0, 1, 8, 0, 0));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      begin
         out_t want;
         want = '0;
         want.if_id_en = 1; want.if_id_flush = 1; want.id_ex_flush = 1;
         want.ex_mem_flush = 1; want.mem_wb_flush = 1;
         compare("async_reset", actual_out(), want);
      end
      step(1, quiet);
      repeat (7) step(0, quiet);
      repeat (200) step(0, rand_stim());

      // Drain, bounded.
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
